write_out_digest: RTL and testbench

- Output-side counterpart of the message-block reader in the SHA256 datapath.
- Accepts the final 256-bit hash (H0..H7) from the compression core in a single cycle.
- Serialises it into the digest memory as one 32-bit word per cycle, with address generation and a memory-ready stall.
- Signals completion to the top-level controller.

---
 rtl/write_out_digest_pkg.sv | 35 +++
 rtl/write_out_digest_if.sv | 32 +++
 rtl/write_out_digest_shift_reg.sv | 38 +++
 rtl/write_out_digest.sv | 133 +++++++++++++
 tb/tb_write_out_digest.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_out_digest_pkg.sv
// write_out_digest_pkg.sv
// Shared SHA256 constants, the digest-writer state type and word helpers
// used by the digest write-out path.
//   WORD_WIDTH   : width of one hash word H0..H7
//   NUMBER_OF_Hs : number of hash words in a digest
//   dig_state_e  : IDLE / WRITE / FINISH
//   word_sel     : word i of a packed digest (word 0 = H0 in the MSBs)
//   byte_rev     : byte-reverse one word
package sha256_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int NUMBER_OF_Hs = 8;
  localparam int DIGEST_WIDTH = WORD_WIDTH * NUMBER_OF_Hs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } dig_state_e;

  function automatic logic [WORD_WIDTH-1:0] word_sel(input logic [DIGEST_WIDTH-1:0] d,
                                                     input int i);
    return d[DIGEST_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH];
  endfunction

  function automatic logic [WORD_WIDTH-1:0] byte_rev(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_WIDTH/8; b++) begin
      r[8*b +: 8] = w[WORD_WIDTH-8-8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/write_out_digest_if.sv
// write_out_digest_if.sv
// Digest-memory write bus.
//   mem_ready         : memory accepts a write this cycle
//   dut__dig__write   : write strobe
//   dut__dig__address : write address
//   dut__dig__data    : write data
// master = digest writer, slave = digest memory.
interface write_out_digest_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int WORD_WIDTH = 32
);

  logic                  mem_ready;
  logic                  dut__dig__write;
  logic [ADDR_WIDTH-1:0] dut__dig__address;
  logic [WORD_WIDTH-1:0] dut__dig__data;

  modport master (
    input  mem_ready,
    output dut__dig__write,
    output dut__dig__address,
    output dut__dig__data
  );

  modport slave (
    output mem_ready,
    input  dut__dig__write,
    input  dut__dig__address,
    input  dut__dig__data
  );

endinterface

// File: rtl/write_out_digest_shift_reg.sv
// write_out_digest_shift_reg.sv
// Load / shift-by-one-word register holding the captured digest. The
// current word is always the top word, so word selection is a shift on
// each accepted write instead of a wide multiplexer.
//   clk, reset : clock, async active-low reset
//   i_load     : capture i_data (wins over i_shift)
//   i_shift    : drop the top word, shift in zeros
//   i_data     : packed digest, word 0 in the MSBs
//   o_word     : current (top) word
module digest_shift_reg #(
  parameter int NUM_WORDS  = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_load,
  input  logic                            i_shift,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] i_data,
  output logic [WORD_WIDTH-1:0]           o_word
);

  localparam int W = NUM_WORDS * WORD_WIDTH;

  logic [W-1:0] r_sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[W-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
    end
  end

  assign o_word = r_sr[W-1 -: WORD_WIDTH];

endmodule

// File: rtl/write_out_digest.sv
// write_out_digest.sv
// Takes the final SHA256 hash in one cycle and writes it to the digest
// memory one word per cycle, honouring a memory-ready stall.
//   clk, reset    : clock, async active-low reset
//   start         : one-cycle pulse, digest valid in the same cycle
//   digest        : {H0..H7}, H0 in the MSBs
//   dig           : digest-memory write bus (master side)
//   busy          : capture until last write accepted
//   done          : one-cycle pulse after the last accepted write
//   start_overrun : sticky, start seen while writing
// Build option DIG_BYTE_SWAP_EN: byte-reverse each word for little-endian
// byte-addressed digest memories; timing is identical either way.
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | presenting word[counter], advances on mem_ready
// FINISH | done pulse; a start here is accepted
module write_out_digest #(
  parameter int NUMBER_OF_Hs = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int BASE_ADDR    = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUMBER_OF_Hs*WORD_WIDTH-1:0] digest,
  write_out_digest_if.master                 dig,
  output logic                               busy,
  output logic                               done,
  output logic                               start_overrun
);

  import sha256_pkg::*;

  localparam int                    CW     = (NUMBER_OF_Hs > 1) ? $clog2(NUMBER_OF_Hs) : 1;
  localparam logic [CW-1:0]         LAST   = CW'(NUMBER_OF_Hs - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  dig_state_e                        r_state, w_state_nxt;
  logic [CW-1:0]                     r_cnt;
  logic [ADDR_WIDTH-1:0]             r_addr;
  logic                              r_overrun;
  logic                              w_load, w_shift;
  logic [NUMBER_OF_Hs*WORD_WIDTH-1:0] w_load_data;
  logic [WORD_WIDTH-1:0]             w_word;

`ifdef DIG_BYTE_SWAP_EN
  always_comb begin
    w_load_data = '0;
    for (int i = 0; i < NUMBER_OF_Hs; i++) begin
      w_load_data[(NUMBER_OF_Hs-1-i)*WORD_WIDTH +: WORD_WIDTH] = byte_rev(word_sel(digest, i));
    end
  end
`else
  assign w_load_data = digest;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (dig.mem_ready) begin
          w_shift = 1'b1;
          if (r_cnt == LAST) w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt  <= '0;
        r_addr <= BASE_A;
      end else if (w_shift) begin
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_addr <= '0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end
      if (start && (r_state == WRITE)) r_overrun <= 1'b1;
    end
  end

  // After the last accepted write every word has been shifted out, so the
  // data register reads zero outside WRITE without extra masking.
  digest_shift_reg #(
    .NUM_WORDS  (NUMBER_OF_Hs),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_word  (w_word)
  );

  assign dig.dut__dig__write   = (r_state == WRITE);
  assign dig.dut__dig__address = r_addr;
  assign dig.dut__dig__data    = w_word;
  assign busy                  = (r_state == WRITE);
  assign done                  = (r_state == FINISH);
  assign start_overrun         = r_overrun;

endmodule

// File: tb/tb_write_out_digest.sv
module tb_write_out_digest;

  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
`ifdef DIG_BYTE_SWAP_EN
  localparam logic [31:0] ABC_W0 = 32'hbf1678ba;
  localparam logic [31:0] ABC_W7 = 32'had1500f2;
`else
  localparam logic [31:0] ABC_W0 = 32'hba7816bf;
  localparam logic [31:0] ABC_W7 = 32'hf20015ad;
`endif

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mem_ready = 1'b1;
  logic [255:0] digest = '0;
  logic         busy0, done0, ovr0, busy1, done1, ovr1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rnd_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   done_due0 = -1, done_due1 = -1;
  int   done_cyc0 = -1, done_cnt0 = 0;
  int   first_wr_cyc0 = -1;
  int   acc0 = 0;
  logic [31:0] mem_img0 [64];
  logic [31:0] mem_img1 [64];

  write_out_digest_if #(.ADDR_WIDTH(6), .WORD_WIDTH(32)) if0 ();
  write_out_digest_if #(.ADDR_WIDTH(6), .WORD_WIDTH(32)) if1 ();
  assign if0.mem_ready = mem_ready;
  assign if1.mem_ready = mem_ready;

  write_out_digest #(.NUMBER_OF_Hs(8), .WORD_WIDTH(32), .ADDR_WIDTH(6), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .digest(digest), .dig(if0),
    .busy(busy0), .done(done0), .start_overrun(ovr0));

  write_out_digest #(.NUMBER_OF_Hs(8), .WORD_WIDTH(32), .ADDR_WIDTH(6), .BASE_ADDR(60)) u_dut60 (
    .clk(clk), .reset(rst_n), .start(start), .digest(digest), .dig(if1),
    .busy(busy1), .done(done1), .start_overrun(ovr1));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: word i of the digest, H0 first, optionally byte-reversed.
  function automatic logic [31:0] exp_word(logic [255:0] d, int i);
    logic [31:0] w;
    w = d[255-32*i -: 32];
`ifdef DIG_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic void push_exp(logic [255:0] d);
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{addr: 6'(i % 64), data: exp_word(d, i), idx: i});
      q1.push_back('{addr: 6'((60 + i) % 64), data: exp_word(d, i), idx: i});
    end
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [255:0] d, bit push);
    digest = d;
    start  = 1'b1;
    if (push) push_exp(d);
    tick();
    start  = 1'b0;
    digest = rand_digest();
  endtask

  task automatic wait_done();
    int n0;
    int k;
    n0 = done_cnt0;
    k  = 0;
    while (done_cnt0 == n0 && k < 200) begin
      tick();
      k++;
    end
    if (done_cnt0 == n0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required one", k);
    end
  endtask

  // Random memory back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) mem_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor, base-0 instance.
  initial forever begin
    @(negedge clk);
    if (done0 || cyc == done_due0) begin
      chk("done0", done0, cyc == done_due0);
      if (done0) begin
        done_cyc0 = cyc;
        done_cnt0++;
      end
    end
    if (if0.dut__dig__write) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write0: addr=%0d data=%h, required no write",
                 if0.dut__dig__address, if0.dut__dig__data);
      end else begin
        chk("addr0", if0.dut__dig__address, q0[0].addr);
        chk("data0", if0.dut__dig__data, q0[0].data);
        if (mem_ready) begin
          mem_img0[if0.dut__dig__address] = if0.dut__dig__data;
          acc0++;
          if (q0[0].idx == 0) first_wr_cyc0 = cyc;
          if (q0[0].idx == 7) done_due0 = cyc + 1;
          void'(q0.pop_front());
        end
      end
    end
  end

  // Scoreboard monitor, base-60 instance.
  initial forever begin
    @(negedge clk);
    if (done1 || cyc == done_due1) chk("done1", done1, cyc == done_due1);
    if (if1.dut__dig__write) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write1: addr=%0d data=%h, required no write",
                 if1.dut__dig__address, if1.dut__dig__data);
      end else begin
        chk("addr1", if1.dut__dig__address, q1[0].addr);
        chk("data1", if1.dut__dig__data, q1[0].data);
        if (mem_ready) begin
          mem_img1[if1.dut__dig__address] = if1.dut__dig__data;
          if (q1[0].idx == 7) done_due1 = cyc + 1;
          void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    int a_start;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_write", if0.dut__dig__write, 0);
    chk("rst_addr", if0.dut__dig__address, 0);
    chk("rst_data", if0.dut__dig__data, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovr", ovr0, 0);
    tick();
    rst_n = 1'b1;

    // "abc" digest, start at cycle 10, memory always ready
    while (cyc < 10) tick();
    n = cyc;
    do_start(ABC, 1'b1);
    for (int c = n + 1; c <= n + 9; c++) begin
      @(negedge clk);
      chk("abc_busy", busy0, c <= n + 8);
      chk("abc_write", if0.dut__dig__write, c <= n + 8);
      tick();
    end
    chk("abc_first_write_cycle", first_wr_cyc0, 11);
    chk("abc_done_cycle", done_cyc0, 19);
    chk("abc_addr0_word", mem_img0[0], ABC_W0);
    chk("abc_addr7_word", mem_img0[7], ABC_W7);
    chk("base60_addr60_word", mem_img1[60], ABC_W0);
    chk("base60_addr3_word", mem_img1[3], ABC_W7);

    // Stall on the cycles that would write addresses 2 and 5
    tick();
    n = cyc;
    do_start(ABC, 1'b1);
    for (int c = n + 1; c <= n + 11; c++) begin
      mem_ready = !(c == n + 3 || c == n + 7);
      @(negedge clk);
      chk("stall_done", done0, c == n + 11);
      chk("stall_busy", busy0, c <= n + 10);
      tick();
    end
    mem_ready = 1'b1;
    chk("stall_all_words", q0.size(), 0);

    // New start accepted in the FINISH cycle
    tick();
    n = cyc;
    do_start(rand_digest(), 1'b1);
    repeat (8) tick();
    do_start(rand_digest(), 1'b1);
    wait_done();
    chk("b2b_first_write_cycle", first_wr_cyc0, n + 10);
    chk("b2b_done_cycle", done_cyc0, n + 18);

    // start while writing is ignored and flagged
    tick();
    n = cyc;
    do_start(rand_digest(), 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("ovr_before", ovr0, 0);
    start  = 1'b1;
    digest = rand_digest();
    tick();
    start  = 1'b0;
    @(negedge clk);
    chk("ovr_set", ovr0, 1);
    chk("ovr_set60", ovr1, 1);
    wait_done();
    repeat (2) tick();
    chk("ovr_sticky", ovr0, 1);

    // Asynchronous reset after the 4th write
    tick();
    a_start = acc0;
    do_start(rand_digest(), 1'b1);
    repeat (3) tick();
    tick();
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    done_due0 = -1;
    done_due1 = -1;
    #1;
    chk("arst_write", if0.dut__dig__write, 0);
    chk("arst_addr", if0.dut__dig__address, 0);
    chk("arst_data", if0.dut__dig__data, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_ovr", ovr0, 0);
    chk("arst_write60", if1.dut__dig__write, 0);
    chk("arst_busy60", busy1, 0);
    chk("arst_ovr60", ovr1, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_accepted_writes", acc0 - a_start, 4);
    n = cyc;
    do_start(rand_digest(), 1'b1);
    wait_done();
    chk("arst_restart_first_cycle", first_wr_cyc0, n + 1);
    chk("arst_restart_words", acc0 - a_start, 12);

    // Random digests under random back-pressure
    rnd_en = 1'b1;
    repeat (25) begin
      repeat ($urandom_range(0, 3)) tick();
      do_start(rand_digest(), 1'b1);
      wait_done();
      chk("rand_q0_empty", q0.size(), 0);
      chk("rand_q1_empty", q1.size(), 0);
    end
    rnd_en = 1'b0;
    tick();
    mem_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
